// File: rtl/alu_seq_unit.sv
// alu_seq_unit -- sequential two-operand ALU with a valid/ready handshake.
//
// Ops: 00 concat {a,b}, 01 add (carry lands in bit WIDTH), 10 shift-left of
// zero-extended a by b (zero once b >= 2*WIDTH), 11 unsigned multiply with a
// full 2*WIDTH-bit product.
// The add, shift and concat ops finish one cycle after accept. Multiply runs a
// shift-add loop that handles one multiplier bit per cycle for WIDTH cycles.
// A finished result stays in HOLD until the consumer takes it.
//
// Optional feature: define ALU_SEQ_FAST_MULT_EN for a single-cycle
// combinational multiply. The default build, with the macro undefined, uses
// the iterative multiplier.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   in_valid/in_ready   request handshake (in_ready only in IDLE)
//   a, b, op            operands and opcode, captured on accept
//   out_valid/out_ready result handshake (out_valid only in HOLD)
//   y, out_op           registered result and the opcode that produced it
//   busy                high whenever the FSM is not in IDLE
module alu_seq_unit #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic [1:0]         out_op,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Shift distances at or above this value push every bit of a out of y.
  localparam logic [WIDTH:0] SH_MAX = (WIDTH+1)'(2*WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]  r_mcand, r_acc, r_y;
  logic [WIDTH-1:0]    r_mplier;
  logic [1:0]          r_op;
  logic [2*WIDTH-1:0]  w_res, w_acc_nxt, w_a_ext, w_b_ext;
  logic                w_accept, w_mul_start, w_mul_last;

  assign w_a_ext    = {{WIDTH{1'b0}}, a};
  assign w_b_ext    = {{WIDTH{1'b0}}, b};
  assign w_accept   = in_valid && (r_state == IDLE);
`ifdef ALU_SEQ_FAST_MULT_EN
  assign w_mul_start = 1'b0;
`else
  assign w_mul_start = w_accept && (op == 2'b11);
`endif
  assign w_mul_last = (r_state == MUL) && (r_cnt == '0);
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Single-cycle result for every op that finishes in one step.
  always_comb begin
    w_res = '0;
    case (op)
      2'b00: w_res = {a, b};
      2'b01: w_res = w_a_ext + w_b_ext;
      2'b10: w_res = ({1'b0, b} >= SH_MAX) ? '0 : (w_a_ext << b);
`ifdef ALU_SEQ_FAST_MULT_EN
      2'b11: w_res = w_a_ext * w_b_ext;
`endif
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_mul_start ? MUL : HOLD;
      MUL:     if (w_mul_last) w_state_nxt = HOLD;
      HOLD:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Multiply keeps its partial product in r_acc. y updates only when the
  // product is complete, so an aborted multiply never shows on the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y      <= '0;
      r_op     <= 2'b00;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          if (w_mul_start) begin
            r_acc    <= '0;
            r_mcand  <= w_a_ext;
            r_mplier <= b;
            r_cnt    <= CW'(WIDTH-1);
          end else begin
            r_y  <= w_res;
            r_op <= op;
          end
        end
        MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - 1'b1;
          if (w_mul_last) begin
            r_y  <= w_acc_nxt;
            r_op <= 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == HOLD);
  assign y         = r_y;
  assign out_op    = r_op;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit. It drives a WIDTH=4 instance, which a cycle-level
// model checks on every cycle, and a WIDTH=8 instance, which is checked
// against literal expected values.
module tb_alu_seq_unit;

`ifdef ALU_SEQ_FAST_MULT_EN
  localparam int MUL_LAT4 = 1;
  localparam int MUL_LAT8 = 1;
`else
  localparam int MUL_LAT4 = 5;
  localparam int MUL_LAT8 = 9;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] a, b;
  logic [1:0] op, out_op;
  logic [7:0] y;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [1:0]  op8, out_op8;
  logic [15:0] y8;

  alu_seq_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .out_op(out_op), .busy(busy));

  alu_seq_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .y(y8), .out_op(out_op8), .busy(busy8));

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic meaning of each op for WIDTH=4.
  function automatic logic [7:0] ref4(input logic [3:0] ra, input logic [3:0] rb,
                                      input logic [1:0] rop);
    int ia, ib;
    ia = int'(ra);
    ib = int'(rb);
    case (rop)
      2'b00:   return 8'(ia * 16 + ib);
      2'b01:   return 8'(ia + ib);
      2'b10:   return (ib >= 8) ? 8'd0 : 8'(ia * (1 << ib));
      default: return 8'(ia * ib);
    endcase
  endfunction

  // Transaction-level model. The DUT is idle, waiting out a latency, or
  // presenting a result. m_y is the value the output must show.
  logic [7:0] m_y, m_py;
  logic [1:0] m_op, m_pop;
  logic       m_valid;
  int         m_wait;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_wait <= 0; m_y <= 8'd0; m_op <= 2'b00;
      m_py <= 8'd0; m_pop <= 2'b00;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_valid <= 1'b1; m_y <= m_py; m_op <= m_pop;
      end
    end else if (in_valid) begin
      if (op == 2'b11 && MUL_LAT4 > 1) begin
        m_py <= ref4(a, b, op); m_pop <= op; m_wait <= MUL_LAT4 - 1;
      end else begin
        m_valid <= 1'b1; m_y <= ref4(a, b, op); m_op <= op;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cyc_out_valid", 64'(out_valid), 64'(m_valid));
    chk("cyc_busy",      64'(busy),      64'(m_valid || m_wait != 0));
    chk("cyc_in_ready",  64'(in_ready),  64'(!(m_valid || m_wait != 0)));
    chk("cyc_y",         64'(y),         64'(m_y));
    chk("cyc_out_op",    64'(out_op),    64'(m_op));
  end

  // Runs one request on the 4-bit DUT. The consumer holds off for `hold`
  // cycles. With `pulse` set, in_valid toggles with junk operands while the
  // DUT is busy.
  task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic [1:0] top,
                      input int hold, input logic [7:0] exp_y, input int exp_lat,
                      input bit pulse, input string name);
    int lat;
    @(negedge clk);
    a = ta; b = tb; op = top; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      if (pulse) begin
        in_valid = ~in_valid; a = 4'($urandom); b = 4'($urandom); op = 2'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_y"}, 64'(y), 64'(exp_y));
    chk({name, "_op"}, 64'(out_op), 64'(top));
    repeat (hold) begin
      @(negedge clk);
      chk({name, "_hold_y"}, 64'(y), 64'(exp_y));
      chk({name, "_hold_rdy"}, 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_idle"}, 64'(in_ready), 64'(1));
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top,
                      input logic [15:0] exp_y, input int exp_lat, input string name);
    int lat;
    @(negedge clk);
    a8 = ta; b8 = tb; op8 = top; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_y"}, 64'(y8), 64'(exp_y));
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    chk({name, "_idle"}, 64'(in_ready8), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_y", 64'(y), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_op", 64'(out_op), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    run4(4'hA, 4'h5, 2'b00, 0, 8'hA5, 1, 1'b0, "concat");
    run4(4'hF, 4'hF, 2'b01, 0, 8'h1E, 1, 1'b0, "add_carry");
    run4(4'h3, 4'h2, 2'b10, 0, 8'h0C, 1, 1'b0, "shl");
    run4(4'h3, 4'h9, 2'b10, 0, 8'h00, 1, 1'b0, "shl_over");
    run4(4'hF, 4'h7, 2'b10, 0, 8'h80, 1, 1'b0, "shl_edge");
    run4(4'hF, 4'hF, 2'b11, 0, 8'hE1, MUL_LAT4, 1'b1, "mul_ff");
    run4(4'h0, 4'hB, 2'b11, 0, 8'h00, MUL_LAT4, 1'b0, "mul_zero");
    run4(4'h6, 4'h9, 2'b00, 3, 8'h69, 1, 1'b0, "concat_hold");

    // Reset lands in the second multiply cycle and must discard the product.
    @(negedge clk);
    a = 4'h7; b = 4'h6; op = 2'b11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_y", 64'(y), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    run4(4'h7, 4'h6, 2'b11, 0, 8'h2A, MUL_LAT4, 1'b0, "mul_after_abort");

    run8(8'hFF, 8'hFF, 2'b11, 16'hFE01, MUL_LAT8, "w8_mul");
    run8(8'h01, 8'h0F, 2'b10, 16'h8000, 1, "w8_shl");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
